// File: rtl/divider_arbiter.sv
// Two-requester front end for a shared iterative divider: round-robin capture,
// single-cycle start pulse, bounded wait with timeout, and a one-hot result strobe.
module divider_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [1:0]       req_valid_in,
    input  logic [WIDTH-1:0] dividend_a_in,
    input  logic [WIDTH-1:0] divisor_a_in,
    input  logic [WIDTH-1:0] dividend_b_in,
    input  logic [WIDTH-1:0] divisor_b_in,
    output logic [1:0]       req_ready_out,
    output logic [1:0]       res_valid_out,
    output logic [WIDTH-1:0] res_quotient_out,
    output logic [WIDTH-1:0] res_remainder_out,
    output logic             res_error_out,
    output logic [WIDTH-1:0] div_dividend_out,
    output logic [WIDTH-1:0] div_divisor_out,
    output logic             div_valid_out,
    input  logic [WIDTH-1:0] div_quotient_in,
    input  logic [WIDTH-1:0] div_remainder_in,
    input  logic             div_valid_in,
    input  logic             div_error_in,
    input  logic             div_busy_in
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] DELIVER = 2'd3;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]       state;
    logic             owner;
    logic             last_b;
    logic [WIDTH-1:0] op_dividend;
    logic [WIDTH-1:0] op_divisor;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic             res_err;
    logic [CW-1:0]    wait_cnt;

    logic             grant_b;
    logic             capture;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;
    logic             unused_busy;

    // On a tie, last_b = 1 hands the grant to A; it resets to 1 so A wins the first tie.
    always_comb begin
        grant_b      = req_valid_in[1] & (~req_valid_in[0] | ~last_b);
        capture      = (state == IDLE) & (|req_valid_in) & ~rst_in;
        sel_dividend = grant_b ? dividend_b_in : dividend_a_in;
        sel_divisor  = grant_b ? divisor_b_in  : divisor_a_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_b      <= 1'b1;
            op_dividend <= '0;
            op_divisor  <= '0;
            res_q       <= '0;
            res_r       <= '0;
            res_err     <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        owner       <= grant_b;
                        last_b      <= grant_b;
                        op_dividend <= sel_dividend;
                        op_divisor  <= sel_divisor;
                        if (sel_divisor == '0) begin
                            res_q   <= '0;
                            res_r   <= '0;
                            res_err <= 1'b1;
                            state   <= DELIVER;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A response arriving on the last allowed cycle still wins over the timeout.
                    if (div_valid_in) begin
                        res_q   <= div_quotient_in;
                        res_r   <= div_remainder_in;
                        res_err <= div_error_in;
                        state   <= DELIVER;
                    end else if (div_error_in || (wait_cnt == CNT_LAST)) begin
                        res_q   <= '0;
                        res_r   <= '0;
                        res_err <= 1'b1;
                        state   <= DELIVER;
                    end
                end
                DELIVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready_out     = capture ? (grant_b ? 2'b10 : 2'b01) : 2'b00;
        res_valid_out     = (state == DELIVER) ? (owner ? 2'b10 : 2'b01) : 2'b00;
        res_quotient_out  = res_q;
        res_remainder_out = res_r;
        res_error_out     = res_err;
        div_dividend_out  = op_dividend;
        div_divisor_out   = op_divisor;
        div_valid_out     = (state == ISSUE);
    end

    // Busy is observed by external monitors only.
    assign unused_busy = div_busy_in;

endmodule
